fetch_queue: RTL and testbench

//  Instruction fetch front end that feeds the decode/control stage of the LEGv8 core.

---
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: LEGv8 instruction fetch front end.
// Owns the PC, issues one imem read per cycle and buffers {pc, instr}
// pairs in a DEPTH-entry FIFO that feeds decode over valid/ready.
// A redirect flushes the FIFO and restarts fetch at the new PC.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [63:0]                imem_addr,
    output logic                       imem_req,
    input  logic [31:0]                imem_data,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [63:0]                out_pc,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [63:0]     pc_q;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [LW-1:0]   level_q;
    logic            pop;
    logic            fetch;

    assign out_valid = (level_q != '0);
    assign pop       = out_valid & out_ready;
    // A full queue may still fetch when the head leaves in the same cycle.
    // Gating with rst keeps imem_req low while reset is asserted.
    assign fetch     = rst & ~redirect_valid & ((level_q < LW'(DEPTH)) | pop);

    assign imem_addr = pc_q;
    assign imem_req  = fetch;
    assign level     = level_q;

    assign head      = mem[rd_ptr];
    // Empty queue presents zeros; reset empties the queue, so outputs read 0 in reset.
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;

    // PC: redirect wins, otherwise advance by one word per fetch (wraps mod 2^64).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[63:2], 2'b00};
        end else if (fetch) begin
            pc_q <= pc_q + 64'd4;
        end
    end

    // Pointers and occupancy: redirect flushes, otherwise push/pop independently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else if (redirect_valid) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (fetch) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            level_q <= level_q + LW'(fetch) - LW'(pop);
        end
    end

    // Entry storage; contents past the level are never observed, so no reset needed.
    always_ff @(posedge clk) begin
        if (fetch) begin
            mem[wr_ptr] <= '{pc: pc_q, instr: imem_data};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenario tasks for fetch_queue.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  level;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .level(level)
    );

    always #5 clk = ~clk;

    // Instruction memory: a pc-derived word so the instr can be predicted from the pc.
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction
    assign imem_data = word_of(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        checks++; if (out_pc !== 64'h0 || out_instr !== 32'h0) begin failures++; $display("FAIL reset_out got=%h/%h exp=0/0", out_pc, out_instr); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (imem_addr !== 64'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL reset_release got=%h/%0b exp=0/1", imem_addr, imem_req); end
    endtask

    task automatic test_stream();
        // rst released with out_ready=1: cycle 0 fetches pc 0.
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_pc !== 64'(4*i)) begin failures++; $display("FAIL stream_pc[%0d] got=%0b/%h exp=1/%h", i, out_valid, out_pc, 64'(4*i)); end
            checks++; if (out_instr !== word_of(64'(4*i))) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, word_of(64'(4*i))); end
            checks++; if (level !== 3'd1) begin failures++; $display("FAIL stream_level[%0d] got=%0d exp=1", i, level); end
        end
    endtask

    task automatic test_fill();
        int exp_lvl;
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_lvl = (k < 4) ? k : 4;
            checks++; if (level !== 3'(exp_lvl)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", k, level, exp_lvl); end
            checks++; if (out_pc !== 64'h0) begin failures++; $display("FAIL fill_head[%0d] got=%h exp=0", k, out_pc); end
            checks++; if (imem_addr !== 64'(4*exp_lvl)) begin failures++; $display("FAIL fill_pc[%0d] got=%h exp=%h", k, imem_addr, 64'(4*exp_lvl)); end
            checks++; if (imem_req !== (exp_lvl < 4)) begin failures++; $display("FAIL fill_req[%0d] got=%0b exp=%0b", k, imem_req, exp_lvl < 4); end
        end
    endtask

    task automatic test_back_to_back();
        // Full queue (head 0, PC 16): pop and fetch every cycle.
        out_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL b2b_req got=%0b exp=1", imem_req); end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (out_pc !== 64'(4*k) || level !== 3'd4) begin failures++; $display("FAIL b2b[%0d] got=%h/%0d exp=%h/4", k, out_pc, level, 64'(4*k)); end
            checks++; if (imem_addr !== 64'(16 + 4*k)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, imem_addr, 64'(16 + 4*k)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        step(); step(); step();
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL redir_pre_level got=%0d exp=3", level); end
        redirect_valid = 1'b1; redirect_pc = 64'h103; out_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req got=%0b exp=0", imem_req); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0d/%0b exp=0/0", level, out_valid); end
        checks++; if (imem_addr !== 64'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h100) begin failures++; $display("FAIL redir_first got=%0b/%h exp=1/100", out_valid, out_pc); end
        checks++; if (out_instr !== word_of(64'h100)) begin failures++; $display("FAIL redir_instr got=%h exp=%h", out_instr, word_of(64'h100)); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_seq [4];
        exp_seq[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_seq[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_seq[2] = 64'h0;
        exp_seq[3] = 64'h4;
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_seq[i]) begin failures++; $display("FAIL wrap[%0d] got=%0b/%h exp=1/%h", i, out_valid, out_pc, exp_seq[i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        step(); step();
        checks++; if (level !== 3'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", level); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL areset_clear got=%0b/%0d exp=0/0", out_valid, level); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL areset_req got=%0b exp=0", imem_req); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL areset_pc got=%h exp=0", imem_addr); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || level !== 3'd1) begin failures++; $display("FAIL areset_restart got=%0b/%h/%0d exp=1/0/1", out_valid, out_pc, level); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
